// File: rtl/mem_bus_arbiter.sv
// Single-port memory arbiter between CPU and video DMA: DMA wins ties, a streak limit guarantees CPU slots.
// Grant is combinational in the request cycle; read data returns to its owner one cycle later.
module mem_bus_arbiter #(
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 8,
    parameter int DMA_MAX_STREAK = 4,
    parameter int STREAK_W       = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cpu_req,
    input  logic                cpu_we,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic [DATA_W-1:0]   cpu_wdata,
    output logic                cpu_gnt,
    output logic                cpu_rvalid,
    output logic [DATA_W-1:0]   cpu_rdata,
    input  logic                dma_req,
    input  logic                dma_we,
    input  logic [ADDR_W-1:0]   dma_addr,
    input  logic [DATA_W-1:0]   dma_wdata,
    output logic                dma_gnt,
    output logic                dma_rvalid,
    output logic [DATA_W-1:0]   dma_rdata,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_we,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic [STREAK_W-1:0] dma_streak
);

    localparam logic [STREAK_W-1:0] MAX_STREAK = STREAK_W'(DMA_MAX_STREAK);

    logic [STREAK_W-1:0] streak;
    logic [ADDR_W-1:0]   held_addr;
    logic [DATA_W-1:0]   held_wdata;
    logic                tag_valid;
    logic                tag_cpu;
    logic                cpu_win;
    logic                dma_win;
    logic                any_win;

    // Reset gates grants combinationally so nothing reaches memory while rst is high.
    always_comb begin
        cpu_win   = 1'b0;
        dma_win   = 1'b0;
        mem_addr  = held_addr;
        mem_wdata = held_wdata;
        mem_we    = 1'b0;
        if (!rst) begin
            dma_win = dma_req && !(cpu_req && (streak == MAX_STREAK));
            cpu_win = cpu_req && !dma_win;
        end
        if (dma_win) begin
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
            mem_we    = dma_we;
        end else if (cpu_win) begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_we    = cpu_we;
        end
    end

    assign any_win = cpu_win || dma_win;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            streak     <= '0;
            held_addr  <= '0;
            held_wdata <= '0;
            tag_valid  <= 1'b0;
            tag_cpu    <= 1'b0;
        end else begin
            if (dma_win && cpu_req) begin
                streak <= (streak == MAX_STREAK) ? MAX_STREAK : streak + STREAK_W'(1);
            end else begin
                streak <= '0;
            end
            if (any_win) begin
                held_addr  <= mem_addr;
                held_wdata <= mem_wdata;
            end
            tag_valid <= any_win && !mem_we;
            tag_cpu   <= cpu_win;
        end
    end

    assign cpu_gnt    = cpu_win;
    assign dma_gnt    = dma_win;
    assign cpu_rvalid = tag_valid && tag_cpu;
    assign dma_rvalid = tag_valid && !tag_cpu;
    assign cpu_rdata  = mem_rdata;
    assign dma_rdata  = mem_rdata;
    assign dma_streak = streak;

endmodule
